// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-counter sequencer with branch, call/return
// through a small return-address stack, and run/idle/halt status.
module fetch_sequencer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [9:0]  RESET_PC = 10'd0
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           start_i,
  input  logic [9:0]                     start_addr_i,
  input  logic                           stall_i,
  input  logic                           branch_i,
  input  logic [9:0]                     branch_target_i,
  input  logic                           call_i,
  input  logic [9:0]                     call_target_i,
  input  logic                           ret_i,
  input  logic                           halt_i,
  output logic [9:0]                     pc_o,
  output logic                           running_o,
  output logic                           done_o,
  output logic                           stack_err_o,
  output logic [$clog2(DEPTH+1)-1:0]     sp_o
);

  localparam int unsigned PC_W  = 10;
  localparam int unsigned SP_W  = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              err_q, err_d;
  logic              running_q, running_d;
  logic              done_q, done_d;

  logic [PC_W-1:0]   stack_q [DEPTH];
  logic              stack_we;
  logic [IDX_W-1:0]  stack_widx;
  logic [PC_W-1:0]   stack_wdata;
  logic [IDX_W-1:0]  pop_idx;
  logic [PC_W-1:0]   pc_inc;
  logic              stack_full;
  logic              stack_empty;

  // Sequential return address (wraps modulo 2^10) and stack occupancy tests.
  assign pc_inc      = pc_q + PC_W'(1);
  assign pop_idx     = IDX_W'(sp_q - SP_W'(1));
  assign stack_full  = (sp_q == SP_W'(DEPTH));
  assign stack_empty = (sp_q == SP_W'(0));

  // Next-state, next-pc and stack-write decode; stall freezes everything.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    sp_d        = sp_q;
    err_d       = err_q;
    stack_we    = 1'b0;
    stack_widx  = IDX_W'(sp_q);
    stack_wdata = pc_inc;

    if (!stall_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            pc_d    = start_addr_i;
            sp_d    = SP_W'(0);
            state_d = ST_RUN;
          end
        end
        ST_HALT: begin
          if (start_i) begin
            pc_d    = start_addr_i;
            sp_d    = SP_W'(0);
            err_d   = 1'b0;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (halt_i) begin
            state_d = ST_HALT;
          end else if (ret_i) begin
            if (stack_empty) begin
              err_d   = 1'b1;
              state_d = ST_HALT;
            end else begin
              pc_d = stack_q[pop_idx];
              sp_d = sp_q - SP_W'(1);
            end
          end else if (call_i) begin
            if (stack_full) begin
              err_d   = 1'b1;
              state_d = ST_HALT;
            end else begin
              stack_we = 1'b1;
              pc_d     = call_target_i;
              sp_d     = sp_q + SP_W'(1);
            end
          end else if (branch_i) begin
            pc_d = branch_target_i;
          end else begin
            pc_d = pc_inc;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_HALT);
  end

  // State, pc and status registers; synchronous reset beats stall and start.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      sp_q      <= SP_W'(0);
      err_q     <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      sp_q      <= sp_d;
      err_q     <= err_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  // Return-address storage; entries above sp are left stale on pop.
  always_ff @(posedge clk_i) begin
    if (!reset_i && stack_we) begin
      stack_q[stack_widx] <= stack_wdata;
    end
  end

  assign pc_o        = pc_q;
  assign running_o   = running_q;
  assign done_o      = done_q;
  assign stack_err_o = err_q;
  assign sp_o        = sp_q;

endmodule
